// File: rtl/cpu_run_monitor_if.sv
// cpu_run_monitor_if: run control, write-back, channel config and status bundle for cpu_run_monitor
interface cpu_run_monitor_if #(parameter int NCH = 2, parameter int DW = 32, parameter int CW = 32);
  logic start;
  logic wb_en;
  logic [4:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic cfg_we;
  logic [2:0] cfg_ch;
  logic [4:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic [CW-1:0] timeout;
  logic busy;
  logic done;
  logic pass;
  logic [NCH-1:0] hit_mask;
  logic [CW-1:0] cycles;
  modport master(output start, wb_en, wb_addr, wb_data, cfg_we, cfg_ch, cfg_addr, cfg_data, timeout,
                 input busy, done, pass, hit_mask, cycles);
  modport slave(input start, wb_en, wb_addr, wb_data, cfg_we, cfg_ch, cfg_addr, cfg_data, timeout,
                output busy, done, pass, hit_mask, cycles);
endinterface

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: watches write-backs for expected register values and reports pass/timeout per run.
// MON_STRICT_EN: hit bits follow the current register value instead of being sticky.
module cpu_run_monitor #(parameter int NCH = 2, parameter int DW = 32, parameter int CW = 32) (
  input logic clk,
  input logic rst,
  cpu_run_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st;
  logic [4:0] ch_addr [NCH];
  logic [DW-1:0] ch_data [NCH];
  logic ch_en [NCH];
  logic [NCH-1:0] en, match, dis, hit_nxt;
  logic [CW-1:0] cyc_nxt;
  logic all_hit, all_nxt, tmo;
`ifdef MON_STRICT_EN
  logic [NCH-1:0] miss;
`endif
  for (genvar j = 0; j < NCH; j++) begin : g_ch
    logic wr;
    assign wr = bus.cfg_we && st != RUN && bus.cfg_ch == 3'(j);
    assign en[j] = ch_en[j];
    assign dis[j] = wr && bus.cfg_addr == '0;
    assign match[j] = bus.wb_en && ch_en[j] && bus.wb_addr != '0 && bus.wb_addr == ch_addr[j] && bus.wb_data == ch_data[j];
`ifdef MON_STRICT_EN
    assign miss[j] = bus.wb_en && ch_en[j] && bus.wb_addr == ch_addr[j] && bus.wb_data != ch_data[j];
`endif
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        ch_addr[j] <= '0;
        ch_data[j] <= '0;
        ch_en[j] <= 1'b0;
      end else if (wr) begin
        ch_addr[j] <= bus.cfg_addr;
        ch_data[j] <= bus.cfg_data;
        ch_en[j] <= bus.cfg_addr != '0;
      end
  end
`ifdef MON_STRICT_EN
  assign hit_nxt = (bus.hit_mask | match) & ~miss;
`else
  assign hit_nxt = bus.hit_mask | match;
`endif
  assign all_hit = (bus.hit_mask & en) == en;
  assign all_nxt = (hit_nxt & en) == en;
  assign cyc_nxt = &bus.cycles ? bus.cycles : bus.cycles + CW'(1);
  assign tmo = bus.timeout != '0 && cyc_nxt >= bus.timeout;
  // A hit landing on the timeout edge still counts, hence pass looks at hit_nxt too
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
      bus.hit_mask <= '0;
      bus.cycles <= '0;
    end else if (st == RUN) begin
      bus.cycles <= cyc_nxt;
      bus.hit_mask <= hit_nxt;
      if (all_hit || tmo) begin
        st <= DONE;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        bus.pass <= all_hit || all_nxt;
      end
    end else if (bus.start) begin
      st <= RUN;
      bus.busy <= 1'b1;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
      bus.hit_mask <= '0;
      bus.cycles <= '0;
    end else begin
      bus.hit_mask <= bus.hit_mask & ~dis;
    end
endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor: table-driven run scenarios plus hand sequences for reset, strict mode and config corners.
module tb_cpu_run_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  cpu_run_monitor_if #(.NCH(2), .DW(32), .CW(32)) bus();
  cpu_run_monitor #(.NCH(2), .DW(32), .CW(32)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0] a0; logic [31:0] d0;
    logic [4:0] a1; logic [31:0] d1;
    logic [31:0] tmo;
    logic [31:0] c0; logic [4:0] wa0; logic [31:0] wd0;
    logic [31:0] c1; logic [4:0] wa1; logic [31:0] wd1;
    logic [31:0] exp_cyc; logic exp_pass; logic [1:0] exp_hit;
  } vec_t;
  localparam logic [31:0] NEVER = 32'hFFFF_FFFF;
  vec_t vt [8];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    #1;
    step();
    rst = 1'b1;
  endtask
  task automatic cfg(input int ch, input logic [4:0] a, input logic [31:0] d);
    bus.cfg_we = 1'b1;
    bus.cfg_ch = 3'(ch);
    bus.cfg_addr = a;
    bus.cfg_data = d;
    step();
    bus.cfg_we = 1'b0;
  endtask
  task automatic run(input int id, input vec_t v);
    int n;
    do_reset();
    cfg(0, v.a0, v.d0);
    cfg(1, v.a1, v.d1);
    bus.timeout = v.tmo;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 2000) begin
      if (bus.cycles == v.c0) begin
        bus.wb_en = 1'b1; bus.wb_addr = v.wa0; bus.wb_data = v.wd0;
      end else if (bus.cycles == v.c1) begin
        bus.wb_en = 1'b1; bus.wb_addr = v.wa1; bus.wb_data = v.wd1;
      end else bus.wb_en = 1'b0;
      step();
      n++;
    end
    bus.wb_en = 1'b0;
    chk($sformatf("v%0d done", id), 64'(bus.done), 64'(1));
    chk($sformatf("v%0d cycles", id), 64'(bus.cycles), 64'(v.exp_cyc));
    chk($sformatf("v%0d pass", id), 64'(bus.pass), 64'(v.exp_pass));
    chk($sformatf("v%0d hit_mask", id), 64'(bus.hit_mask), 64'(v.exp_hit));
    repeat (3) step();
    chk($sformatf("v%0d cycles hold", id), 64'(bus.cycles), 64'(v.exp_cyc));
  endtask
  initial begin
    bus.start = 1'b0; bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.timeout = '0;
    vt[0] = '{5'd15, 32'd2, 5'd0, 32'd0, 32'd1000, 32'd40, 5'd15, 32'd2, NEVER, 5'd0, 32'd0, 32'd42, 1'b1, 2'b01};
    vt[1] = '{5'd14, 32'd5, 5'd15, 32'd2, 32'd100, 32'd5, 5'd14, 32'd5, NEVER, 5'd0, 32'd0, 32'd100, 1'b0, 2'b01};
    vt[2] = '{5'd15, 32'd2, 5'd0, 32'd0, 32'd10, 32'd9, 5'd15, 32'd2, NEVER, 5'd0, 32'd0, 32'd10, 1'b1, 2'b01};
    vt[3] = '{5'd0, 32'd0, 5'd0, 32'd0, 32'd50, 32'd0, 5'd0, 32'd0, NEVER, 5'd0, 32'd0, 32'd1, 1'b1, 2'b00};
    vt[4] = '{5'd3, 32'd7, 5'd3, 32'd7, 32'd0, 32'd5, 5'd3, 32'd7, NEVER, 5'd0, 32'd0, 32'd7, 1'b1, 2'b11};
    vt[5] = '{5'd3, 32'd7, 5'd0, 32'd0, 32'd20, 32'd5, 5'd3, 32'd8, NEVER, 5'd0, 32'd0, 32'd20, 1'b0, 2'b00};
    vt[6] = '{5'd3, 32'd7, 5'd4, 32'd9, 32'd0, 32'd2, 5'd3, 32'd7, 32'd10, 5'd4, 32'd9, 32'd12, 1'b1, 2'b11};
    vt[7] = '{5'd15, 32'd2, 5'd0, 32'd0, 32'd10, 32'd10, 5'd15, 32'd2, NEVER, 5'd0, 32'd0, 32'd10, 1'b0, 2'b00};
    #2;
    rst = 1'b0;
    #1;
    chk("reset busy", 64'(bus.busy), 64'(0));
    chk("reset done", 64'(bus.done), 64'(0));
    chk("reset pass", 64'(bus.pass), 64'(0));
    chk("reset hit_mask", 64'(bus.hit_mask), 64'(0));
    chk("reset cycles", 64'(bus.cycles), 64'(0));
    step();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) run(i, vt[i]);
    // strict vs sticky hit, and start ignored while running
    do_reset();
    cfg(0, 5'd14, 32'd5);
    cfg(1, 5'd15, 32'd2);
    bus.timeout = '0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd14; bus.wb_data = 32'd5;
    step();
    chk("strict first hit", 64'(bus.hit_mask), 64'(1));
    bus.wb_data = 32'd7;
    step();
    bus.wb_en = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
`ifdef MON_STRICT_EN
    chk("strict hit_mask", 64'(bus.hit_mask), 64'(0));
`else
    chk("sticky hit_mask", 64'(bus.hit_mask), 64'(1));
`endif
    chk("start ignored cycles", 64'(bus.cycles), 64'(3));
    chk("start ignored busy", 64'(bus.busy), 64'(1));
    // config write during RUN ignored, then reset mid-run
    do_reset();
    cfg(0, 5'd15, 32'd2);
    cfg(1, 5'd0, 32'd0);
    bus.timeout = '0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    bus.cfg_we = 1'b1; bus.cfg_ch = 3'd0; bus.cfg_addr = 5'd0; bus.cfg_data = 32'd0;
    step();
    bus.cfg_we = 1'b0;
    step();
    chk("cfg in run ignored", 64'({bus.busy, bus.done}), 64'(2'b10));
    chk("cycles mid run", 64'(bus.cycles), 64'(6));
    rst = 1'b0;
    #1;
    chk("async reset busy", 64'(bus.busy), 64'(0));
    chk("async reset cycles", 64'(bus.cycles), 64'(0));
    chk("async reset done", 64'({bus.done, bus.pass, bus.hit_mask}), 64'(0));
    step();
    rst = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("restart busy", 64'(bus.busy), 64'(1));
    step();
    chk("restart done", 64'({bus.done, bus.pass}), 64'(2'b11));
    chk("restart cycles", 64'(bus.cycles), 64'(1));
    // out-of-range channel write must not enable any channel
    do_reset();
    cfg(2, 5'd9, 32'd1);
    bus.timeout = 32'd30;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("cfg_ch oob done", 64'({bus.done, bus.pass}), 64'(2'b11));
    chk("cfg_ch oob cycles", 64'(bus.cycles), 64'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
